skip_table_loader: RTL and testbench
====================================

Name: skip_table_loader

Overview:
Configuration sequencer for the fetch-stage skip table and PC CAM. It accepts load, invalidate, flush and allocate commands on a valid/ready interface. It converts each command into an ordered series of single-word writes on the table write port (enable/address/data). It also tracks slot occupancy, and orders the writes so that a half-written entry never produces a CAM hit.

Parameters:
SKIP_TABLE_SIZE, 16, number of table slots; power of two, at least 2
IDX_W, $clog2(SKIP_TABLE_SIZE), slot index width (derived)
BLOCK_IDX, 0, table block index; must equal package SkipTableBlockIdx, occupies WriteAddressOut[31:IDX_W+2]

Ports:
ClockIn  in  1  single clock, rising edge
AsyncResetIn  in  1  asynchronous, active-low reset
CmdValidIn  in  1  command valid
CmdReadyOut  out  1  command accepted when Valid&&Ready at a rising edge
CmdOpIn  in  2  0=LOAD, 1=INVAL, 2=FLUSH, 3=ALLOC
CmdIdxIn  in  IDX_W  target slot (LOAD, INVAL); ignored otherwise
CmdPCIn  in  32  CAM PC (LOAD, ALLOC)
CmdEntryIn  in  32  packed entry word: [31]valid, [30]skipType, [29:25]ptrReg, [24]rs2Ignore, [23:20]rs1RB, [19:16]rs2RB, [15:12]rdRB, [7:0]SkipCount
WriteEnOut  out  1  table write strobe, one word per cycle
WriteAddressOut  out  32  {BLOCK_IDX, 1'b0, idx, offset}; offset 0=CAM PC, 1=entry word
WriteDataOut  out  32  write data
RespValidOut  out  1  one-cycle completion pulse
RespIdxOut  out  IDX_W  slot written (ALLOC: chosen slot; FLUSH: SKIP_TABLE_SIZE-1)
RespErrOut  out  1  qualified by RespValidOut; 1 = ALLOC rejected because the table is full
OccupancyOut  out  SKIP_TABLE_SIZE  per-slot occupied flags
FullOut  out  1  &OccupancyOut

Behaviour:
- Reset (AsyncResetIn=0, takes effect immediately):
  - State goes to IDLE and occupancy is cleared.
  - All outputs are 0, including CmdReadyOut.
  - An in-flight sequence is abandoned with no further writes and no response; the loader does not resume it after reset.
- States: IDLE, DIS, PC, ENT, INV, FLSH, RSP.
- CmdReadyOut=1 only in IDLE. Command fields are latched on acceptance; inputs are ignored while busy.
- All outputs are registered. A write issued in a state is visible on the port during that state's cycle; WriteEnOut=0 in IDLE and RSP.
- LOAD, accepted at edge T:
  - DIS (T+1): write offset 1, data = CmdEntryIn with bit31 forced 0.
  - PC (T+2): write offset 0, data = CmdPCIn.
  - ENT (T+3): write offset 1, data = CmdEntryIn with bit31 forced 1. Set occupancy[idx].
  - RSP (T+4): RespValidOut=1, RespErrOut=0, RespIdxOut=idx.
  - IDLE at T+5.
- ALLOC:
  - On acceptance, select the lowest-index slot whose occupancy bit is 0, using the occupancy value at the accept edge.
  - Then run the LOAD sequence on that slot.
  - If FullOut=1 at acceptance: go directly to RSP with RespErrOut=1 and RespIdxOut=0; no writes, occupancy unchanged.
- INVAL:
  - INV (T+1): write offset 1, data 0; clear occupancy[idx].
  - RSP (T+2).
  - INVAL of an unoccupied slot still writes, and is not an error.
- FLUSH:
  - FLSH: SKIP_TABLE_SIZE consecutive cycles writing offset 1, data 0, for idx 0..SKIP_TABLE_SIZE-1 in ascending order.
  - Occupancy is cleared on the last flush cycle.
  - Then RSP. Total latency is SKIP_TABLE_SIZE+1 cycles to the response.
- The flush index counter is IDX_W bits wide; the final-cycle condition is counter == SKIP_TABLE_SIZE-1, and there is no wrap write.
- Address bit IDX_W+1 is always 0. WriteAddressOut upper bits are constant BLOCK_IDX.
- LOAD to an already-occupied slot overwrites it using the same DIS/PC/ENT ordering; occupancy stays 1.
- FullOut and OccupancyOut update on the same edge as the corresponding write (ENT, INV, last FLSH).
- At most one write per cycle; a command is never accepted in the same cycle a write is issued.

Test Plan:
- Reset release, then LOAD idx=3, PC=0x0000_1000, entry=0x8123_4005 -> T+1 wr addr {BLOCK_IDX,0,3,1} data 0x0123_4005; T+2 offset 0 data 0x1000; T+3 offset 1 data 0x8123_4005; T+4 RespValid, RespIdx=3, Occupancy=0x0008.
- ALLOC x3 from empty with entry bit31=0 -> slots 0,1,2 written with bit31 forced 1 in ENT; RespIdx 0,1,2; occupancy 0x0007.
- Fill all 16 slots, ALLOC -> no WriteEnOut, RespValid with RespErr=1 at T+1, FullOut stays 1.
- INVAL idx=1 after the previous fill -> one write, offset 1, data 0; occupancy 0xFFFD; next ALLOC returns idx 1.
- FLUSH -> 16 writes to idx 0..15, offset 1, data 0 on consecutive cycles; occupancy 0 at the last write; RespIdx=15 at T+17; CmdValidIn held during FLUSH is not accepted until IDLE.
- AsyncResetIn dropped at the PC cycle of a LOAD -> WriteEnOut=0 immediately, no RespValidOut; after release CmdReadyOut=1 and occupancy=0.

Source files
------------

// File: rtl/skip_table_loader.sv
// Turns load/invalidate/flush/allocate commands into ordered single-word writes
// for the fetch-stage skip table and PC CAM, and tracks which slots are occupied.
module skip_table_loader #(
  parameter int SKIP_TABLE_SIZE = 16,
  parameter int IDX_W           = $clog2(SKIP_TABLE_SIZE),
  parameter int BLOCK_IDX       = 0
) (
  input  logic                       ClockIn,
  input  logic                       AsyncResetIn,
  input  logic                       CmdValidIn,
  output logic                       CmdReadyOut,
  input  logic [1:0]                 CmdOpIn,
  input  logic [IDX_W-1:0]           CmdIdxIn,
  input  logic [31:0]                CmdPCIn,
  input  logic [31:0]                CmdEntryIn,
  output logic                       WriteEnOut,
  output logic [31:0]                WriteAddressOut,
  output logic [31:0]                WriteDataOut,
  output logic                       RespValidOut,
  output logic [IDX_W-1:0]           RespIdxOut,
  output logic                       RespErrOut,
  output logic [SKIP_TABLE_SIZE-1:0] OccupancyOut,
  output logic                       FullOut,
  output logic [2:0]                 DebugStateOut
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DIS  = 3'd1,
    PC   = 3'd2,
    ENT  = 3'd3,
    INV  = 3'd4,
    FLSH = 3'd5,
    RSP  = 3'd6
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_INVAL = 2'd1;
  localparam logic [1:0] OP_FLUSH = 2'd2;
  localparam logic [1:0] OP_ALLOC = 2'd3;

  localparam int               BLK_W     = 30 - IDX_W;
  localparam logic [BLK_W-1:0] BlockBits = BLK_W'(BLOCK_IDX);
  localparam logic [IDX_W-1:0] LastIdx   = IDX_W'(SKIP_TABLE_SIZE - 1);
  localparam logic [IDX_W-1:0] PenultIdx = IDX_W'(SKIP_TABLE_SIZE - 2);
  localparam logic [31:0]      ValidBit  = 32'h8000_0000;

  state_t                       state;
  logic [IDX_W-1:0]             idxQ;
  logic [31:0]                  pcQ;
  logic [31:0]                  entryQ;
  logic [IDX_W-1:0]             flushCnt;
  logic [IDX_W-1:0]             freeIdx;
  logic [SKIP_TABLE_SIZE-1:0]   occNext;
  logic                         accept;

  // Handshake: a command transfers on a rising edge where CmdValidIn && CmdReadyOut;
  // ready is only raised in IDLE, so inputs are don't-care while a sequence runs.
  assign accept        = (state == IDLE) && CmdReadyOut && CmdValidIn;
  assign DebugStateOut = state;

  function automatic logic [31:0] wrAddr(input logic [IDX_W-1:0] idx, input logic offset);
    return {BlockBits, 1'b0, idx, offset};
  endfunction

  always_comb begin
    freeIdx = '0;
    for (int i = SKIP_TABLE_SIZE - 1; i >= 0; i--) begin
      if (!OccupancyOut[i]) freeIdx = IDX_W'(i);
    end
  end

  // Occupancy moves on the same edge that launches the matching write.
  always_comb begin
    occNext = OccupancyOut;
    case (state)
      IDLE:    if (accept && CmdOpIn == OP_INVAL) occNext[CmdIdxIn] = 1'b0;
      PC:      occNext[idxQ] = 1'b1;
      FLSH:    if (flushCnt == PenultIdx) occNext = '0;
      default: ;
    endcase
  end

  always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
    if (!AsyncResetIn) begin
      state           <= IDLE;
      idxQ            <= '0;
      pcQ             <= '0;
      entryQ          <= '0;
      flushCnt        <= '0;
      OccupancyOut    <= '0;
      FullOut         <= 1'b0;
      CmdReadyOut     <= 1'b0;
      WriteEnOut      <= 1'b0;
      WriteAddressOut <= '0;
      WriteDataOut    <= '0;
      RespValidOut    <= 1'b0;
      RespIdxOut      <= '0;
      RespErrOut      <= 1'b0;
    end else begin
      OccupancyOut <= occNext;
      FullOut      <= &occNext;
      CmdReadyOut  <= 1'b0;
      WriteEnOut   <= 1'b0;
      RespValidOut <= 1'b0;
      RespErrOut   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            pcQ    <= CmdPCIn;
            entryQ <= CmdEntryIn;
            idxQ   <= CmdIdxIn;
            case (CmdOpIn)
              OP_LOAD: begin
                state           <= DIS;
                WriteEnOut      <= 1'b1;
                WriteAddressOut <= wrAddr(CmdIdxIn, 1'b1);
                WriteDataOut    <= CmdEntryIn & ~ValidBit;
              end
              OP_ALLOC: begin
                if (FullOut) begin
                  state        <= RSP;
                  RespValidOut <= 1'b1;
                  RespErrOut   <= 1'b1;
                  RespIdxOut   <= '0;
                end else begin
                  idxQ            <= freeIdx;
                  state           <= DIS;
                  WriteEnOut      <= 1'b1;
                  WriteAddressOut <= wrAddr(freeIdx, 1'b1);
                  WriteDataOut    <= CmdEntryIn & ~ValidBit;
                end
              end
              OP_INVAL: begin
                state           <= INV;
                WriteEnOut      <= 1'b1;
                WriteAddressOut <= wrAddr(CmdIdxIn, 1'b1);
                WriteDataOut    <= '0;
              end
              default: begin
                state           <= FLSH;
                flushCnt        <= '0;
                WriteEnOut      <= 1'b1;
                WriteAddressOut <= wrAddr('0, 1'b1);
                WriteDataOut    <= '0;
              end
            endcase
          end else begin
            CmdReadyOut <= 1'b1;
          end
        end
        DIS: begin
          state           <= PC;
          WriteEnOut      <= 1'b1;
          WriteAddressOut <= wrAddr(idxQ, 1'b0);
          WriteDataOut    <= pcQ;
        end
        PC: begin
          // The valid bit lands last so a half-written entry never hits in the CAM.
          state           <= ENT;
          WriteEnOut      <= 1'b1;
          WriteAddressOut <= wrAddr(idxQ, 1'b1);
          WriteDataOut    <= entryQ | ValidBit;
        end
        ENT, INV: begin
          state        <= RSP;
          RespValidOut <= 1'b1;
          RespIdxOut   <= idxQ;
        end
        FLSH: begin
          if (flushCnt == LastIdx) begin
            state        <= RSP;
            RespValidOut <= 1'b1;
            RespIdxOut   <= LastIdx;
          end else begin
            flushCnt        <= flushCnt + 1'b1;
            WriteEnOut      <= 1'b1;
            WriteAddressOut <= wrAddr(flushCnt + 1'b1, 1'b1);
            WriteDataOut    <= '0;
          end
        end
        RSP: begin
          state       <= IDLE;
          CmdReadyOut <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skip_table_loader.sv
// Directed bench for skip_table_loader: write ordering, allocation, invalidate,
// flush and mid-sequence reset, with hand-computed expected values.
module tb_skip_table_loader;

  localparam int N     = 16;
  localparam int IW    = 4;
  localparam int BLOCK = 5;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [IW-1:0] cmd_idx;
  logic [31:0]   cmd_pc;
  logic [31:0]   cmd_entry;
  logic          wr_en;
  logic [31:0]   wr_addr;
  logic [31:0]   wr_data;
  logic          resp_valid;
  logic [IW-1:0] resp_idx;
  logic          resp_err;
  logic [N-1:0]  occupancy;
  logic          full;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] LOAD = 2'd0, INVAL = 2'd1, FLUSH = 2'd2, ALLOC = 2'd3;

  skip_table_loader #(.SKIP_TABLE_SIZE(N), .BLOCK_IDX(BLOCK)) dut (
    .ClockIn(clk), .AsyncResetIn(rst_n),
    .CmdValidIn(cmd_valid), .CmdReadyOut(cmd_ready), .CmdOpIn(cmd_op),
    .CmdIdxIn(cmd_idx), .CmdPCIn(cmd_pc), .CmdEntryIn(cmd_entry),
    .WriteEnOut(wr_en), .WriteAddressOut(wr_addr), .WriteDataOut(wr_data),
    .RespValidOut(resp_valid), .RespIdxOut(resp_idx), .RespErrOut(resp_err),
    .OccupancyOut(occupancy), .FullOut(full), .DebugStateOut(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int idx, input int off);
    return (BLOCK << (IW + 2)) | (idx << 1) | off;
  endfunction

  // driver tasks
  task automatic send(input logic [1:0] op, input logic [IW-1:0] idx,
                      input logic [31:0] pc, input logic [31:0] entry);
    int n = 0;
    while (!cmd_ready && n < 40) begin
      tick();
      n++;
    end
    check("ready_wait", {31'b0, cmd_ready}, 32'd1);
    cmd_op    = op;
    cmd_idx   = idx;
    cmd_pc    = pc;
    cmd_entry = entry;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_write(input string tag, input int idx, input int off, input logic [31:0] data);
    check({tag, "_en"},   {31'b0, wr_en}, 32'd1);
    check({tag, "_addr"}, wr_addr, exp_addr(idx, off));
    check({tag, "_data"}, wr_data, data);
  endtask

  task automatic expect_resp(input string tag, input int idx, input logic err);
    check({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_idx"},   {28'b0, resp_idx}, idx);
    check({tag, "_err"},   {31'b0, resp_err}, {31'b0, err});
    check({tag, "_noen"},  {31'b0, wr_en}, 32'd0);
  endtask

  task automatic do_alloc(input int exp_idx, input logic [31:0] pc, input logic [31:0] entry);
    send(ALLOC, '0, pc, entry);
    expect_write("alloc_dis", exp_idx, 1, entry & 32'h7FFF_FFFF);
    tick();
    expect_write("alloc_pc", exp_idx, 0, pc);
    tick();
    expect_write("alloc_ent", exp_idx, 1, entry | 32'h8000_0000);
    tick();
    expect_resp("alloc_rsp", exp_idx, 1'b0);
    tick();
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_idx   = '0;
    cmd_pc    = '0;
    cmd_entry = '0;
    rst_n     = 1'b0;
    tick();
    tick();
    check("rst_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_wren", {31'b0, wr_en}, 32'd0);
    check("rst_resp", {31'b0, resp_valid}, 32'd0);
    check("rst_occ", {16'b0, occupancy}, 32'd0);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_addr", wr_addr, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_ready", {31'b0, cmd_ready}, 32'd1);

    // LOAD idx 3
    send(LOAD, 4'd3, 32'h0000_1000, 32'h8123_4005);
    expect_write("load_dis", 3, 1, 32'h0123_4005);
    check("load_dis_ready", {31'b0, cmd_ready}, 32'd0);
    tick();
    expect_write("load_pc", 3, 0, 32'h0000_1000);
    check("load_pc_occ", {16'b0, occupancy}, 32'h0000);
    tick();
    expect_write("load_ent", 3, 1, 32'h8123_4005);
    check("load_ent_occ", {16'b0, occupancy}, 32'h0008);
    tick();
    expect_resp("load_rsp", 3, 1'b0);
    check("load_rsp_occ", {16'b0, occupancy}, 32'h0008);
    tick();
    check("load_idle_ready", {31'b0, cmd_ready}, 32'd1);

    // INVAL idx 3 empties the table again
    send(INVAL, 4'd3, 32'h0, 32'h0);
    expect_write("inv3", 3, 1, 32'h0);
    check("inv3_occ", {16'b0, occupancy}, 32'h0000);
    tick();
    expect_resp("inv3_rsp", 3, 1'b0);
    tick();

    // ALLOC x3 from empty
    for (int i = 0; i < 3; i++) do_alloc(i, 32'h0000_2000 + i * 4, 32'h0000_0AB0 + i);
    check("alloc3_occ", {16'b0, occupancy}, 32'h0007);
    check("alloc3_full", {31'b0, full}, 32'd0);

    // fill remaining slots
    for (int i = 3; i < N; i++) do_alloc(i, 32'h0000_3000 + i * 4, 32'h1234_0000 + i);
    check("fill_occ", {16'b0, occupancy}, 32'hFFFF);
    check("fill_full", {31'b0, full}, 32'd1);

    // ALLOC when full: immediate error response, no writes
    send(ALLOC, '0, 32'hDEAD_0000, 32'h0000_0001);
    expect_resp("full_rsp", 0, 1'b1);
    check("full_occ", {16'b0, occupancy}, 32'hFFFF);
    check("full_full", {31'b0, full}, 32'd1);
    tick();
    check("full_after_noen", {31'b0, wr_en}, 32'd0);
    check("full_after_noresp", {31'b0, resp_valid}, 32'd0);
    check("full_after_ready", {31'b0, cmd_ready}, 32'd1);

    // INVAL idx 1, then ALLOC reuses slot 1
    send(INVAL, 4'd1, 32'h0, 32'hFFFF_FFFF);
    expect_write("inv1", 1, 1, 32'h0);
    check("inv1_occ", {16'b0, occupancy}, 32'hFFFD);
    check("inv1_full", {31'b0, full}, 32'd0);
    tick();
    expect_resp("inv1_rsp", 1, 1'b0);
    tick();
    do_alloc(1, 32'h0000_4000, 32'h0055_0000);
    check("realloc_occ", {16'b0, occupancy}, 32'hFFFF);

    // LOAD over an occupied slot keeps its occupancy bit set
    send(LOAD, 4'd5, 32'h0000_5000, 32'h0000_0077);
    expect_write("over_dis", 5, 1, 32'h0000_0077);
    check("over_dis_occ", {16'b0, occupancy}, 32'hFFFF);
    tick();
    expect_write("over_pc", 5, 0, 32'h0000_5000);
    tick();
    expect_write("over_ent", 5, 1, 32'h8000_0077);
    tick();
    expect_resp("over_rsp", 5, 1'b0);
    tick();

    // FLUSH with CmdValidIn held throughout; the follow-up LOAD waits for IDLE
    check("flush_pre_ready", {31'b0, cmd_ready}, 32'd1);
    cmd_op    = FLUSH;
    cmd_valid = 1'b1;
    tick();
    cmd_op    = LOAD;
    cmd_idx   = 4'd7;
    cmd_pc    = 32'h0000_7000;
    cmd_entry = 32'h0000_0099;
    for (int i = 0; i < N; i++) begin
      expect_write("flush_wr", i, 1, 32'h0);
      check("flush_ready", {31'b0, cmd_ready}, 32'd0);
      check("flush_occ", {16'b0, occupancy}, (i == N - 1) ? 32'h0000 : 32'hFFFF);
      tick();
    end
    expect_resp("flush_rsp", 15, 1'b0);
    check("flush_rsp_occ", {16'b0, occupancy}, 32'h0000);
    tick();
    check("flush_idle_ready", {31'b0, cmd_ready}, 32'd1);
    check("flush_idle_noen", {31'b0, wr_en}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    expect_write("held_dis", 7, 1, 32'h0000_0099);
    tick();
    expect_write("held_pc", 7, 0, 32'h0000_7000);
    tick();
    expect_write("held_ent", 7, 1, 32'h8000_0099);
    tick();
    expect_resp("held_rsp", 7, 1'b0);
    check("held_occ", {16'b0, occupancy}, 32'h0080);
    tick();

    // reset dropped during the PC cycle of a LOAD
    send(LOAD, 4'd9, 32'h0000_9000, 32'h0000_0011);
    tick();
    expect_write("rstmid_pc", 9, 0, 32'h0000_9000);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_noen", {31'b0, wr_en}, 32'd0);
    check("rstmid_occ", {16'b0, occupancy}, 32'h0000);
    check("rstmid_ready", {31'b0, cmd_ready}, 32'd0);
    tick();
    check("rstmid_noresp", {31'b0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("after_rst_noen", {31'b0, wr_en}, 32'd0);
      check("after_rst_noresp", {31'b0, resp_valid}, 32'd0);
    end
    check("after_rst_ready", {31'b0, cmd_ready}, 32'd1);
    check("after_rst_occ", {16'b0, occupancy}, 32'h0000);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
